// File: rtl/uart_rx_lsb.sv
// uart_rx_lsb: UART receiver with an AXI-Stream style output holding register.
// It expects an idle-high line carrying LSB-first frames: one start bit,
// DATA_WIDTH data bits and one stop bit.
//
// Timing: one bit period is 8*P clk cycles, where P is the value of prescale
// captured when the start bit is detected. Each bit is sampled at its middle.
//
// Ports:
//   clk            sole clock, rising edge
//   rst            synchronous active-high reset
//   rxd            serial line input
//   prescale       bit period = prescale*8 clk cycles; 0 disables reception
//   m_axis_tdata   received payload (bit-reversed when BIG_ENDIAN=1)
//   m_axis_tvalid  payload valid, held until accepted
//   m_axis_tready  consumer accepts payload
//   busy           a frame is being received
//   overrun_error  one-cycle pulse: a good frame replaced an unaccepted payload
//   frame_error    one-cycle pulse: stop bit sampled low, payload dropped
//
// Optional build macro UART_RX_SYNC2_EN: when defined, rxd passes through a
// two-flop synchronizer before it is used. This adds 2 cycles of latency.
//
// State table:
//   IDLE  | waiting for the line to go low (start edge)
//   START | waiting for the middle of the start bit to confirm it
//   DATA  | sampling the DATA_WIDTH payload bits, LSB first
//   STOP  | waiting for the middle of the stop bit, then deliver or flag
module uart_rx_lsb #(
    parameter int DATA_WIDTH = 8,
    parameter bit BIG_ENDIAN = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rxd,
    input  logic [15:0]           prescale,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  busy,
    output logic                  overrun_error,
    output logic                  frame_error
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    state_t                state, state_nxt;
    logic                  line;
    logic [15:0]           p_reg;
    logic [18:0]           cnt;
    logic [18:0]           period;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] payload;
    logic                  tick;
    logic                  start_det;

`ifdef UART_RX_SYNC2_EN
    logic sync1, sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= rxd;
            sync2 <= sync1;
        end
    end

    assign line = sync2;
`else
    assign line = rxd;
`endif

    // The period uses the prescale value latched at the start edge, so a
    // change to prescale in the middle of a frame has no effect on it.
    assign period = {p_reg, 3'b000};
    assign tick   = (cnt == 19'd0);
    assign busy   = (state != IDLE);

    generate
        if (BIG_ENDIAN) begin : g_rev
            for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
                assign payload[i] = shreg[DATA_WIDTH-1-i];
            end
        end else begin : g_fwd
            assign payload = shreg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start_det = 1'b0;
        case (state)
            IDLE: begin
                if (!line && prescale != 16'd0) begin
                    state_nxt = START;
                    start_det = 1'b1;
                end
            end
            START: begin
                if (tick) state_nxt = line ? IDLE : DATA;
            end
            DATA: begin
                if (tick && bit_cnt == LAST_BIT) state_nxt = STOP;
            end
            STOP: begin
                if (tick) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_reg         <= '0;
            cnt           <= '0;
            bit_cnt       <= '0;
            shreg         <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            overrun_error <= 1'b0;
            frame_error   <= 1'b0;
        end else begin
            overrun_error <= 1'b0;
            frame_error   <= 1'b0;
            if (m_axis_tvalid && m_axis_tready) m_axis_tvalid <= 1'b0;

            case (state)
                IDLE: begin
                    if (start_det) begin
                        p_reg   <= prescale;
                        // Half a bit period (4P) to reach the start-bit middle.
                        cnt     <= {1'b0, prescale, 2'b00} - 19'd1;
                        bit_cnt <= '0;
                    end
                end
                START: begin
                    cnt <= tick ? period - 19'd1 : cnt - 19'd1;
                end
                DATA: begin
                    if (tick) begin
                        // Shift right so the first (LSB) bit ends up in bit 0.
                        shreg   <= (shreg >> 1) | (DATA_WIDTH'(line) << (DATA_WIDTH - 1));
                        bit_cnt <= bit_cnt + BW'(1);
                        cnt     <= period - 19'd1;
                    end else begin
                        cnt <= cnt - 19'd1;
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (line) begin
                            m_axis_tdata  <= payload;
                            m_axis_tvalid <= 1'b1;
                            // Replacing the old payload in the same cycle it
                            // is accepted does not count as an overrun.
                            overrun_error <= m_axis_tvalid && !m_axis_tready;
                        end else begin
                            frame_error <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 19'd1;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule
